font_rom_arbiter: RTL and testbench

- Shares the single font ROM between two glyph requesters running on clk_100MHz: requester 0 is the timer/digit text layer and requester 1 is the status/banner text layer.
- Grants at most one ROM access per cycle, drives the ROM address, and routes each returned font row back to the requester that issued it.
- Read data is returned with fixed latency and a per-requester valid pulse.

---
 rtl/font_rom_arbiter_if.sv | 45 ++++
 rtl/font_rom_arbiter.sv | 128 ++++++++++++
 tb/tb_font_rom_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/font_rom_arbiter_if.sv
// Font ROM arbiter bus: two glyph requesters, the shared ROM port and the status flag.
// master = requester/ROM side, slave = arbiter side.
// Lock inputs exist only when FONT_ARB_LOCK_EN is defined.
interface font_rom_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
);
  // Requester 0 (timer/digit text layer)
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rd_valid0;
  // Requester 1 (status/banner text layer)
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rd_valid1;
`ifdef FONT_ARB_LOCK_EN
  logic              lock0;
  logic              lock1;
`endif
  // Shared return path and ROM port
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] font_word;
  logic              busy;

  modport master (
    output req0, addr0, req1, addr1,
`ifdef FONT_ARB_LOCK_EN
    output lock0, lock1,
`endif
    output font_word,
    input  gnt0, rd_valid0, gnt1, rd_valid1, rd_data, rom_addr, busy
  );

  modport slave (
    input  req0, addr0, req1, addr1,
`ifdef FONT_ARB_LOCK_EN
    input  lock0, lock1,
`endif
    input  font_word,
    output gnt0, rd_valid0, gnt1, rd_valid1, rd_data, rom_addr, busy
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Font ROM arbiter: shares one font ROM between two glyph requesters.
// One grant per cycle (round-robin or fixed priority), registered ROM address,
// {valid,id} tag pipeline that routes each returned row back with a valid pulse.
// Optional macro FONT_ARB_LOCK_EN adds lock0/lock1 so a requester can keep the ROM
// for a whole glyph.
module font_rom_arbiter #(
  parameter int unsigned ADDR_W         = 11,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ROM_LATENCY    = 1,  // legal range 1..4
  parameter int unsigned FIXED_PRIORITY = 0   // 0: round-robin, 1: requester 0 wins
) (
  input logic               clk_100MHz,
  input logic               reset,
  font_rom_arbiter_if.slave bus
);

  logic                  r_ptr;        // tie owner: 0 -> requester 0, 1 -> requester 1
  logic [ADDR_W-1:0]     r_rom_addr;
  logic [DATA_W-1:0]     r_rd_data;
  logic                  r_rd_valid0;
  logic                  r_rd_valid1;
  logic [ROM_LATENCY:0]  r_pipe_vld;   // stage k valid k+1 cycles after the grant edge
  logic [ROM_LATENCY:0]  r_pipe_id;

  logic w_gnt0;
  logic w_gnt1;
  logic w_gnt_any;
  logic w_lock0;
  logic w_lock1;

`ifdef FONT_ARB_LOCK_EN
  logic r_last_vld;  // at least one grant since reset
  logic r_last_id;   // most recently granted requester

  assign w_lock0 = r_last_vld & ~r_last_id & bus.lock0 & bus.req0;
  assign w_lock1 = r_last_vld &  r_last_id & bus.lock1 & bus.req1;

  // Remember who was granted last so its lock can hold the ROM.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_last_vld <= 1'b0;
      r_last_id  <= 1'b0;
    end else if (w_gnt_any) begin
      r_last_vld <= 1'b1;
      r_last_id  <= w_gnt1;
    end
  end
`else
  assign w_lock0 = 1'b0;
  assign w_lock1 = 1'b0;
`endif

  // Grant decision: active lock first, then single requester, then tie-break.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_lock0) begin
      w_gnt0 = 1'b1;
    end else if (w_lock1) begin
      w_gnt1 = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      if ((FIXED_PRIORITY != 0) || !r_ptr) begin
        w_gnt0 = 1'b1;
      end else begin
        w_gnt1 = 1'b1;
      end
    end else begin
      w_gnt0 = bus.req0;
      w_gnt1 = bus.req1;
    end
  end

  assign w_gnt_any = w_gnt0 | w_gnt1;

  // Round-robin pointer hands the tie to the requester not just served.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (w_gnt_any) begin
      r_ptr <= ~w_gnt1;
    end
  end

  // ROM address loads the granted requester's address, otherwise holds.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_rom_addr <= '0;
    end else if (w_gnt_any) begin
      r_rom_addr <= w_gnt1 ? bus.addr1 : bus.addr0;
    end
  end

  // Tag pipeline tracks each access until its ROM word is valid; reset drops in-flight reads.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_pipe_vld <= '0;
      r_pipe_id  <= '0;
    end else begin
      r_pipe_vld <= {r_pipe_vld[ROM_LATENCY-1:0], w_gnt_any};
      r_pipe_id  <= {r_pipe_id[ROM_LATENCY-1:0], w_gnt1};
    end
  end

  // Capture the ROM word when the last stage is valid and pulse the owner's valid.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_rd_data   <= '0;
      r_rd_valid0 <= 1'b0;
      r_rd_valid1 <= 1'b0;
    end else begin
      r_rd_valid0 <= r_pipe_vld[ROM_LATENCY] & ~r_pipe_id[ROM_LATENCY];
      r_rd_valid1 <= r_pipe_vld[ROM_LATENCY] &  r_pipe_id[ROM_LATENCY];
      if (r_pipe_vld[ROM_LATENCY]) begin
        r_rd_data <= bus.font_word;
      end
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid0 = r_rd_valid0;
  assign bus.rd_valid1 = r_rd_valid1;
  // The rd_valid registers are the final pipeline stage, so a read stays busy until delivered.
  assign bus.busy      = (|r_pipe_vld) | r_rd_valid0 | r_rd_valid1;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed self-checking bench for font_rom_arbiter (round-robin and fixed-priority
// instances, ROM latency 1). Lock steps build only with FONT_ARB_LOCK_EN.
module tb_font_rom_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  font_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) bus_rr ();
  font_rom_arbiter_if #(.ADDR_W(11), .DATA_W(8)) bus_fp ();

  font_rom_arbiter #(
    .ADDR_W(11), .DATA_W(8), .ROM_LATENCY(1), .FIXED_PRIORITY(0)
  ) dut_rr (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus_rr.slave)
  );

  font_rom_arbiter #(
    .ADDR_W(11), .DATA_W(8), .ROM_LATENCY(1), .FIXED_PRIORITY(1)
  ) dut_fp (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus_fp.slave)
  );

  // Font ROM contents: row = (addr[7:0] ^ 0x5A) + addr[10:8].
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    return (a[7:0] ^ 8'h5A) + {5'd0, a[10:8]};
  endfunction

  // One-cycle ROM models.
  always @(posedge clk) bus_rr.font_word <= rom_fn(bus_rr.rom_addr);
  always @(posedge clk) bus_fp.font_word <= rom_fn(bus_fp.rom_addr);

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected rows in grant order for the alternating and fixed-priority runs.
  logic [7:0] exp_rr [8] = '{8'h1A, 8'hDB, 8'h1B, 8'hDC, 8'h18, 8'hD9, 8'h19, 8'hDA};
  logic [7:0] exp_fp [8] = '{8'h1A, 8'h1B, 8'h18, 8'h19, 8'h1E, 8'h1F, 8'h1C, 8'h1D};

  initial begin
    bus_rr.req0 = 1'b0; bus_rr.addr0 = '0; bus_rr.req1 = 1'b0; bus_rr.addr1 = '0;
    bus_fp.req0 = 1'b0; bus_fp.addr0 = '0; bus_fp.req1 = 1'b0; bus_fp.addr1 = '0;
`ifdef FONT_ARB_LOCK_EN
    bus_rr.lock0 = 1'b0; bus_rr.lock1 = 1'b0;
    bus_fp.lock0 = 1'b0; bus_fp.lock1 = 1'b0;
`endif

    // Reset state
    tick(); tick();
    chk("rst_rom_addr", bus_rr.rom_addr, 0);
    chk("rst_rd_data", bus_rr.rd_data, 0);
    chk("rst_rd_valid0", bus_rr.rd_valid0, 0);
    chk("rst_rd_valid1", bus_rr.rd_valid1, 0);
    chk("rst_busy", bus_rr.busy, 0);
    reset = 1'b0;

    // Single request from requester 0
    bus_rr.req0 = 1'b1; bus_rr.addr0 = 11'h123; #1;
    chk("single0_gnt0", bus_rr.gnt0, 1);
    chk("single0_gnt1", bus_rr.gnt1, 0);
    tick();
    bus_rr.req0 = 1'b0; #1;
    chk("single0_gnt0_drop", bus_rr.gnt0, 0);
    chk("single0_rom_addr", bus_rr.rom_addr, 11'h123);
    chk("single0_busy_c1", bus_rr.busy, 1);
    chk("single0_noval_c1", bus_rr.rd_valid0, 0);
    tick(); #1;
    chk("single0_busy_c2", bus_rr.busy, 1);
    chk("single0_noval_c2", bus_rr.rd_valid0, 0);
    tick(); #1;
    chk("single0_valid_c3", bus_rr.rd_valid0, 1);
    chk("single0_other_c3", bus_rr.rd_valid1, 0);
    chk("single0_data_c3", bus_rr.rd_data, 8'h7A);
    chk("single0_busy_c3", bus_rr.busy, 1);
    tick(); #1;
    chk("single0_valid_c4", bus_rr.rd_valid0, 0);
    chk("single0_busy_c4", bus_rr.busy, 0);
    chk("single0_hold_c4", bus_rr.rd_data, 8'h7A);

    // Single request from requester 1 (pointer now at 1, moves back to 0)
    bus_rr.req1 = 1'b1; bus_rr.addr1 = 11'h0FF; #1;
    chk("single1_gnt1", bus_rr.gnt1, 1);
    chk("single1_gnt0", bus_rr.gnt0, 0);
    tick();
    bus_rr.req1 = 1'b0;
    tick(); tick(); #1;
    chk("single1_valid1", bus_rr.rd_valid1, 1);
    chk("single1_valid0", bus_rr.rd_valid0, 0);
    chk("single1_data", bus_rr.rd_data, 8'hA5);
    tick();

    // Both requesting for 8 cycles: alternating grants, responses 3 cycles later
    for (int c = 0; c < 11; c++) begin
      bus_rr.req0  = (c < 8);
      bus_rr.req1  = (c < 8);
      bus_rr.addr0 = 11'h040 + 11'((c + 1) / 2);
      bus_rr.addr1 = 11'h180 + 11'(c / 2);
      #1;
      if (c < 8) begin
        chk("rr_gnt0", bus_rr.gnt0, (c % 2 == 0));
        chk("rr_gnt1", bus_rr.gnt1, (c % 2 == 1));
      end
      if (c >= 3) begin
        chk("rr_rd_valid0", bus_rr.rd_valid0, ((c - 3) % 2 == 0));
        chk("rr_rd_valid1", bus_rr.rd_valid1, ((c - 3) % 2 == 1));
        chk("rr_rd_data", bus_rr.rd_data, exp_rr[c-3]);
      end else begin
        chk("rr_early_valid", {bus_rr.rd_valid1, bus_rr.rd_valid0}, 0);
      end
      tick();
    end

    // Requester 1 asks once while requester 0 wins, then withdraws
    bus_rr.req0 = 1'b1; bus_rr.addr0 = 11'h155;
    bus_rr.req1 = 1'b1; bus_rr.addr1 = 11'h2AA; #1;
    chk("wd_gnt0", bus_rr.gnt0, 1);
    chk("wd_gnt1", bus_rr.gnt1, 0);
    tick();
    bus_rr.req0 = 1'b0; bus_rr.req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_no_gnt1", bus_rr.gnt1, 0);
      chk("wd_no_valid1", bus_rr.rd_valid1, 0);
      chk("wd_valid0", bus_rr.rd_valid0, (i == 2));
      if (i == 2) chk("wd_data", bus_rr.rd_data, 8'h10);
      tick();
    end

    // Reset one cycle after a grant: the in-flight read must never return
    bus_rr.req0 = 1'b1; bus_rr.addr0 = 11'h3C5; #1;
    chk("rstf_gnt0", bus_rr.gnt0, 1);
    tick();
    bus_rr.req0 = 1'b0;
    reset = 1'b1; #1;
    chk("rstf_rom_addr", bus_rr.rom_addr, 0);
    chk("rstf_rd_data", bus_rr.rd_data, 0);
    chk("rstf_busy", bus_rr.busy, 0);
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rstf_no_valid", {bus_rr.rd_valid1, bus_rr.rd_valid0}, 0);
      chk("rstf_idle_busy", bus_rr.busy, 0);
      tick();
    end
    // Pointer was at requester 1 before reset; reset returns it to requester 0
    bus_rr.req0 = 1'b1; bus_rr.req1 = 1'b1; #1;
    chk("rstf_ptr_gnt0", bus_rr.gnt0, 1);
    chk("rstf_ptr_gnt1", bus_rr.gnt1, 0);
    tick();
    bus_rr.req0 = 1'b0; bus_rr.req1 = 1'b0;
    tick(); tick(); tick();

`ifdef FONT_ARB_LOCK_EN
    // Locked requester 0 keeps the ROM for 16 rows, then requester 1 wins
    bus_rr.lock0 = 1'b1; bus_rr.req0 = 1'b1; bus_rr.req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("lock_gnt0", bus_rr.gnt0, 1);
      chk("lock_gnt1", bus_rr.gnt1, 0);
      tick();
    end
    bus_rr.lock0 = 1'b0; #1;
    chk("unlock_gnt1", bus_rr.gnt1, 1);
    chk("unlock_gnt0", bus_rr.gnt0, 0);
    tick();
    bus_rr.req0 = 1'b0; bus_rr.req1 = 1'b0;
    tick(); tick(); tick();
`endif

    // Fixed priority: requester 0 wins every contested cycle
    for (int c = 0; c < 11; c++) begin
      bus_fp.req0  = (c < 8);
      bus_fp.req1  = (c < 8);
      bus_fp.addr0 = 11'h040 + 11'(c);
      bus_fp.addr1 = 11'h180;
      #1;
      if (c < 8) begin
        chk("fp_gnt0", bus_fp.gnt0, 1);
        chk("fp_gnt1", bus_fp.gnt1, 0);
      end
      chk("fp_no_valid1", bus_fp.rd_valid1, 0);
      chk("fp_rd_valid0", bus_fp.rd_valid0, (c >= 3));
      if (c >= 3) chk("fp_rd_data", bus_fp.rd_data, exp_fp[c-3]);
      tick();
    end
    bus_fp.req0 = 1'b0; bus_fp.req1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
